core_sequencer: RTL
===================

# core_sequencer

Multi-cycle control sequencer for the RV32I core. It owns the program counter and the instruction-retired counter, and steps each instruction through fetch, decode, execute, memory and writeback. In each phase it drives the strobes for the shared memory block, the instruction register, the register file and the PC. It sits between the decoder/ALU/branch-compare datapath and the `memory` block, replacing ad-hoc per-opcode sequencing with one explicit FSM.

## Interface
- `IMEM_LATENCY`, default 1: cycles from `imem_rd` assertion to valid instruction data; must be ≥1.
- `DMEM_LATENCY`, default 1: cycles from `dmem_rd`/`dmem_wren` assertion to access completion; must be ≥1.
- `RESET_PC`, default 32'h1000: PC value after reset.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: execution enable, sampled in IDLE and at the end of WRITEBACK.
- `opcode` in 7: decoded opcode of the held instruction, valid from DECODE onward.
- `branch_taken` in 1: branch-compare result; the datapath holds it stable from EXECUTE through WRITEBACK.
- `target` in 32: jal/jalr/branch target address; held stable EXECUTE through WRITEBACK.
- `pc` out 32: current instruction address, registered.
- `imem_rd` out 1: instruction fetch strobe.
- `ir_load` out 1: load instruction register from memory output.
- `dmem_rd` out 1: data read strobe.
- `dmem_wren` out 1: data write strobe.
- `rf_wr_en` out 1: register file write enable.
- `rf_wr_sel` out 2: writeback source. 0 = ALU, 1 = memory, 2 = pc+4, 3 = imm_u.
- `state` out 3: current FSM state encoding.
- `halted` out 1: FSM is in HALT.
- `illegal` out 1: sticky flag, illegal opcode seen.
- `retired` out 32: count of completed instructions.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6. Value 7 is unreachable and recovers to IDLE.
- IDLE:
  - If `run`=1, go to FETCH; otherwise stay.
  - All strobes are 0.
- FETCH:
  - `imem_rd`=1 for every cycle in the state.
  - A wait counter counts IMEM_LATENCY cycles.
  - On the last cycle, `ir_load`=1 and the FSM goes to DECODE.
- DECODE (1 cycle), branching on `opcode`:
  - 1110011 (ecall/ebreak): go to HALT.
  - Opcode not in the legal set: go to HALT and set `illegal`.
  - Otherwise go to EXECUTE.
  - Legal set: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111. Opcode 0001111 (fence) executes as a no-op.
- EXECUTE (1 cycle): opcodes 0000011 and 0100011 go to MEM; all others go to WRITEBACK.
- MEM:
  - Lasts DMEM_LATENCY cycles, then goes to WRITEBACK.
  - Load: `dmem_rd`=1 on every MEM cycle.
  - Store: `dmem_wren`=1 on the first MEM cycle only. A store is never written twice.
- WRITEBACK (1 cycle):
  - `rf_wr_en`=1 except for branch (1100011), store (0100011) and fence (0001111).
  - `rf_wr_sel` by opcode: lui → 3; jal/jalr → 2; load → 1; op, op-imm and auipc → 0.
  - PC update at the cycle end:
    - `{target[31:1],1'b0}` if the opcode is jal or jalr, or if it is a branch with `branch_taken`=1.
    - Otherwise pc+4.
  - `retired` increments at the cycle end.
  - Next state is FETCH if `run`=1, else IDLE.
- HALT:
  - Terminal state; `halted`=1.
  - Left only by `reset`; `run` is ignored.
  - PC and `retired` are frozen, with no writeback for the halting instruction.
- Arithmetic: PC and `retired` wrap modulo 2^32 (0xFFFFFFFC+4 → 0; 0xFFFFFFFF → 0).
- Deasserting `run` mid-instruction does not abort. The instruction completes and the FSM then enters IDLE.

## Timing
- Reset values: state=IDLE, `pc`=RESET_PC, `retired`=0, `illegal`=0, `halted`=0, all strobes 0, `rf_wr_sel`=0. They take effect immediately on `reset` assertion, with no clock needed.
- Reset during any state aborts the instruction. No pending PC update, register write or memory strobe reaches any output after assertion.
- `pc`, `retired`, `illegal` and `state` are registered. Strobes, `rf_wr_sel` and `halted` are combinational decodes of the state register, wait counter and `opcode`; they are glitch-free relative to `clk`.
- `rf_wr_sel` is 0 outside WRITEBACK.
- Latency per instruction, counted FETCH entry to FETCH entry:
  - Non-memory: IMEM_LATENCY+3 cycles.
  - Load/store: IMEM_LATENCY+DMEM_LATENCY+3 cycles.
  - With defaults: 4 and 5 cycles.
- The wait counter is ⌈log2(max(IMEM_LATENCY,DMEM_LATENCY)+1)⌉ bits and clears on every state change.
- `opcode`, `branch_taken` and `target` are sampled only in the states listed above; changes outside those states have no effect.

## Test plan
- ALU op (opcode 0110011), defaults, `run`=1 from reset release at cycle 0:
  - States FETCH, DECODE, EXECUTE, WRITEBACK on cycles 1–4.
  - `ir_load`=1 on cycle 1.
  - Cycle 4: `rf_wr_en`=1, `rf_wr_sel`=0.
  - After cycle 4: `pc`=0x1004, `retired`=1.
- Load with DMEM_LATENCY=2: `dmem_rd`=1 on both MEM cycles, `dmem_wren`=0, WRITEBACK `rf_wr_sel`=1, `pc`+4.
- Store with DMEM_LATENCY=3: `dmem_wren`=1 for exactly one cycle (first MEM), `rf_wr_en`=0 in WRITEBACK, `pc`+4.
- Control flow:
  - Branch taken, `target`=0x0FF9 → `pc`=0x0FF8, `rf_wr_en`=0.
  - Branch not taken → `pc`+4.
  - jal, `target`=0x2000 → `pc`=0x2000, `rf_wr_sel`=2, `rf_wr_en`=1.
- Halt cases:
  - `opcode`=0000000 → HALT the cycle after DECODE; `illegal`=1, `halted`=1; `pc` and `retired` unchanged.
  - Toggling `run` keeps the FSM in HALT.
  - `opcode`=1110011 → HALT with `illegal`=0.
- Reset and run control:
  - Assert `reset` mid-cycle during the first MEM cycle of a store → immediately `dmem_wren`=0, state=IDLE, `pc`=0x1000, `retired`=0.
  - Deassert `run` during EXECUTE → instruction retires, then IDLE.

Source files
------------

// File: rtl/core_sequencer_if.sv
// ---------------------------------------------------------------------------
// core_sequencer_if
//   Bundles the sequencer's link to the datapath and the shared memory block.
//   master: the sequencer. It drives the memory, IR and register-file strobes
//           and receives decode/branch information from the datapath.
//   slave : the datapath/memory side.
//
//   imem_rd      seq -> mem   instruction fetch strobe
//   ir_load      seq -> dp    load instruction register from memory output
//   dmem_rd      seq -> mem   data read strobe
//   dmem_wren    seq -> mem   data write strobe
//   rf_wr_en     seq -> dp    register file write enable
//   rf_wr_sel    seq -> dp    writeback source (0 ALU, 1 mem, 2 pc+4, 3 imm_u)
//   opcode       dp  -> seq   decoded opcode of the held instruction
//   branch_taken dp  -> seq   branch-compare result
//   target       dp  -> seq   jal/jalr/branch target address
// ---------------------------------------------------------------------------
interface core_sequencer_if;
    logic        imem_rd;
    logic        ir_load;
    logic        dmem_rd;
    logic        dmem_wren;
    logic        rf_wr_en;
    logic [1:0]  rf_wr_sel;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic [31:0] target;

    modport master (
        output imem_rd, ir_load, dmem_rd, dmem_wren, rf_wr_en, rf_wr_sel,
        input  opcode, branch_taken, target
    );

    modport slave (
        input  imem_rd, ir_load, dmem_rd, dmem_wren, rf_wr_en, rf_wr_sel,
        output opcode, branch_taken, target
    );
endinterface

// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle control FSM for the RV32I core. Owns the PC and the
//   retired-instruction counter and steps each instruction through
//   FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK.
//
//   clk      in   single clock, rising edge
//   reset    in   asynchronous active-high reset
//   run      in   execution enable (sampled in IDLE and at end of WRITEBACK)
//   bus      --   core_sequencer_if.master: strobes out, opcode/branch/target in
//   pc       out  current instruction address (registered)
//   state    out  FSM state encoding (registered)
//   halted   out  FSM is in HALT
//   illegal  out  sticky illegal-opcode flag (registered)
//   retired  out  completed instruction count (registered)
//
//   Strobes, rf_wr_sel and halted are decoded from the state register, the
//   wait counter and opcode only, so they carry no input-path glitches.
// ---------------------------------------------------------------------------
module core_sequencer #(
    parameter int unsigned IMEM_LATENCY = 1,
    parameter int unsigned DMEM_LATENCY = 1,
    parameter logic [31:0] RESET_PC     = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    core_sequencer_if.master bus,
    output logic [31:0]      pc,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [31:0]      retired
);
    localparam int unsigned MAX_LAT = (IMEM_LATENCY > DMEM_LATENCY) ? IMEM_LATENCY : DMEM_LATENCY;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] IMEM_LAST = CNT_W'(IMEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] DMEM_LAST = CNT_W'(DMEM_LATENCY - 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] wait_cnt;

    logic       imem_rd_c;
    logic       ir_load_c;
    logic       dmem_rd_c;
    logic       dmem_wren_c;
    logic       rf_wr_en_c;
    logic [1:0] rf_wr_sel_c;
    logic       redirect;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_FENCE: is_legal = 1'b1;
            default:                                     is_legal = 1'b0;
        endcase
    endfunction

    // Jumps always redirect; branches only when the compare says so.
    assign redirect = (bus.opcode == OP_JAL) || (bus.opcode == OP_JALR) ||
                      ((bus.opcode == OP_BRANCH) && bus.branch_taken);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= S_IDLE;
            wait_cnt <= '0;
            pc       <= RESET_PC;
            retired  <= '0;
            illegal  <= 1'b0;
        end else begin
            // Counter clears on every state change; only the waiting
            // states override this with an increment.
            wait_cnt <= '0;
            case (st)
                S_IDLE: begin
                    if (run) st <= S_FETCH;
                end
                S_FETCH: begin
                    if (wait_cnt == IMEM_LAST) st <= S_DECODE;
                    else                       wait_cnt <= wait_cnt + CNT_W'(1);
                end
                S_DECODE: begin
                    if (bus.opcode == OP_SYSTEM) begin
                        st <= S_HALT;
                    end else if (!is_legal(bus.opcode)) begin
                        st      <= S_HALT;
                        illegal <= 1'b1;
                    end else begin
                        st <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if ((bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE)) st <= S_MEM;
                    else                                                     st <= S_WRITEBACK;
                end
                S_MEM: begin
                    if (wait_cnt == DMEM_LAST) st <= S_WRITEBACK;
                    else                       wait_cnt <= wait_cnt + CNT_W'(1);
                end
                S_WRITEBACK: begin
                    pc      <= redirect ? (bus.target & ~32'h1) : pc + 32'd4;
                    retired <= retired + 32'd1;
                    st      <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    st <= S_HALT;
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        imem_rd_c   = 1'b0;
        ir_load_c   = 1'b0;
        dmem_rd_c   = 1'b0;
        dmem_wren_c = 1'b0;
        rf_wr_en_c  = 1'b0;
        rf_wr_sel_c = 2'd0;
        case (st)
            S_FETCH: begin
                imem_rd_c = 1'b1;
                ir_load_c = (wait_cnt == IMEM_LAST);
            end
            S_MEM: begin
                dmem_rd_c   = (bus.opcode == OP_LOAD);
                // Store strobes only on the first MEM cycle so it is never
                // written twice on multi-cycle memories.
                dmem_wren_c = (bus.opcode == OP_STORE) && (wait_cnt == '0);
            end
            S_WRITEBACK: begin
                rf_wr_en_c = !((bus.opcode == OP_BRANCH) || (bus.opcode == OP_STORE) ||
                               (bus.opcode == OP_FENCE));
                if (bus.opcode == OP_LUI)                                   rf_wr_sel_c = 2'd3;
                else if ((bus.opcode == OP_JAL) || (bus.opcode == OP_JALR)) rf_wr_sel_c = 2'd2;
                else if (bus.opcode == OP_LOAD)                             rf_wr_sel_c = 2'd1;
                else                                                        rf_wr_sel_c = 2'd0;
            end
            default: ;
        endcase
    end

    assign bus.imem_rd   = imem_rd_c;
    assign bus.ir_load   = ir_load_c;
    assign bus.dmem_rd   = dmem_rd_c;
    assign bus.dmem_wren = dmem_wren_c;
    assign bus.rf_wr_en  = rf_wr_en_c;
    assign bus.rf_wr_sel = rf_wr_sel_c;
    assign halted        = (st == S_HALT);
    assign state         = st;

endmodule
